// File: rtl/router_pkg.sv
// Shared definitions for the router packet source: FSM encoding, address limit,
// LFSR polynomial and the parity corruption mask.
package router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } tx_state_e;

    localparam logic [1:0] ADDR_MAX            = 2'd2;
    // Feedback taps s[7], s[5], s[4], s[3]
    localparam logic [7:0] LFSR_TAPS           = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEFAULT   = 8'h01;
    localparam logic [7:0] PARITY_CORRUPT_MASK = 8'hFF;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/router_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and advance enable.
module router_lfsr8
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] state
);

    logic [7:0] state_q;
    logic [7:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (en) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= LFSR_SEED_DEFAULT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: header, LFSR payload and XOR parity byte per start,
// with busy back-pressure, an idle gap between packets and a completed-packet counter.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int IDLE_GAP = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       dest_addr,
    input  logic [5:0]       payload_len,
    input  logic [7:0]       seed,
    input  logic             corrupt_parity,
    input  logic             busy,
    output logic             pkt_valid,
    output logic [7:0]       data_out,
    output logic             tx_ready,
    output logic             done,
    output logic             cfg_err,
    output logic [7:0]       exp_parity,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

    tx_state_e        state_q, state_d;
    logic [5:0]       len_q, len_d;
    logic [5:0]       rem_q, rem_d;
    logic [1:0]       addr_q, addr_d;
    logic             corrupt_q, corrupt_d;
    logic [7:0]       parity_q, parity_d;
    logic [7:0]       exp_parity_q, exp_parity_d;
    logic [3:0]       gap_q, gap_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic       lfsr_load;
    logic       lfsr_en;
    logic [7:0] lfsr_state;
    logic [7:0] seed_eff;
    logic       start_ok;
    logic       accept;

    // An all-zero seed would lock the LFSR, so it is promoted to the default seed.
    assign seed_eff = (seed == 8'h00) ? LFSR_SEED_DEFAULT : seed;
    assign start_ok = (dest_addr <= ADDR_MAX) && (payload_len != 6'd0);
    assign accept   = !busy && (state_q inside {ST_HEADER, ST_PAYLOAD, ST_PARITY});

    router_lfsr8 u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .load   (lfsr_load),
        .en     (lfsr_en),
        .seed   (seed_eff),
        .state  (lfsr_state)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rem_d        = rem_q;
        addr_d       = addr_q;
        corrupt_d    = corrupt_q;
        parity_d     = parity_q;
        exp_parity_d = exp_parity_q;
        gap_d        = gap_q;
        done_d       = 1'b0;
        cfg_err_d    = 1'b0;
        pkt_cnt_d    = pkt_cnt_q;
        lfsr_load    = 1'b0;
        lfsr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        len_d     = payload_len;
                        addr_d    = dest_addr;
                        corrupt_d = corrupt_parity;
                        parity_d  = {payload_len, dest_addr};
                        lfsr_load = 1'b1;
                        state_d   = ST_HEADER;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_HEADER: begin
                if (accept) begin
                    rem_d   = len_q;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    parity_d = parity_q ^ lfsr_state;
                    lfsr_en  = 1'b1;
                    rem_d    = rem_q - 6'd1;
                    if (rem_q == 6'd1) begin
                        exp_parity_d = parity_q ^ lfsr_state;
                        state_d      = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (accept) begin
                    done_d    = 1'b1;
                    pkt_cnt_d = pkt_cnt_q + 1'b1;
                    gap_d     = GAP_LAST;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            rem_q        <= '0;
            addr_q       <= '0;
            corrupt_q    <= 1'b0;
            parity_q     <= '0;
            exp_parity_q <= '0;
            gap_q        <= '0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            addr_q       <= addr_d;
            corrupt_q    <= corrupt_d;
            parity_q     <= parity_d;
            exp_parity_q <= exp_parity_d;
            gap_q        <= gap_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    // Outputs decode straight from held state, so busy freezes them for free.
    always_comb begin
        data_out = 8'h00;
        case (state_q)
            ST_HEADER:  data_out = {len_q, addr_q};
            ST_PAYLOAD: data_out = lfsr_state;
            ST_PARITY:  data_out = corrupt_q ? (parity_q ^ PARITY_CORRUPT_MASK) : parity_q;
            default:    data_out = 8'h00;
        endcase
    end

    assign pkt_valid  = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
    assign tx_ready   = (state_q == ST_IDLE);
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign exp_parity = exp_parity_q;
    assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus queues hand-computed packet bytes,
// a monitor decodes the router byte stream and compares against the queue.
module tb_router_pkt_tx;

    localparam int IDLE_GAP = 2;
    localparam int CNT_W    = 2;

    logic             clock;
    logic             resetn;
    logic             start;
    logic [1:0]       dest_addr;
    logic [5:0]       payload_len;
    logic [7:0]       seed;
    logic             corrupt_parity;
    logic             busy;
    logic             pkt_valid;
    logic [7:0]       data_out;
    logic             tx_ready;
    logic             done;
    logic             cfg_err;
    logic [7:0]       exp_parity;
    logic [CNT_W-1:0] pkt_cnt;

    router_pkt_tx #(.IDLE_GAP(IDLE_GAP), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .start          (start),
        .dest_addr      (dest_addr),
        .payload_len    (payload_len),
        .seed           (seed),
        .corrupt_parity (corrupt_parity),
        .busy           (busy),
        .pkt_valid      (pkt_valid),
        .data_out       (data_out),
        .tx_ready       (tx_ready),
        .done           (done),
        .cfg_err        (cfg_err),
        .exp_parity     (exp_parity),
        .pkt_cnt        (pkt_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]       data;
        logic             valid;
        logic             last;
        logic [7:0]       par;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sbq[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // v holds the packet bytes MSB-first; the last byte is the true parity.
    task automatic push_pkt(input logic [63:0] v, input int n, input logic corrupt);
        exp_t e;
        exp_cnt = exp_cnt + 1'b1;
        for (int i = 0; i < n; i++) begin
            e.data  = v[8*(n-1-i) +: 8];
            e.valid = (i != n - 1);
            e.last  = (i == n - 1);
            e.par   = v[7:0];
            e.cnt   = exp_cnt;
            if (e.last && corrupt) e.data = e.data ^ 8'hFF;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (tx_ready !== 1'b1 && t < 300) begin
            @(posedge clock); #1;
            t++;
        end
        check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sbq.size() != 0 && t < 300) begin
            @(posedge clock); #1;
            t++;
        end
        check("queue_drain", sbq.size(), 32'd0);
        wait_ready();
    endtask

    task automatic send(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s,
                        input logic c, input logic [63:0] v, input int n);
        wait_ready();
        dest_addr = a; payload_len = l; seed = s; corrupt_parity = c; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        push_pkt(v, n, c);
    endtask

    // Monitor: decodes header length, tracks payload/parity phases, checks done,
    // pkt_cnt, exp_parity and the idle gap length.
    initial begin : monitor
        int               rem;
        bit               in_pkt, par_phase, done_exp, gap_meas;
        int               gap_run;
        logic [CNT_W-1:0] cnt_exp;
        exp_t             e;
        in_pkt = 0; par_phase = 0; done_exp = 0; gap_meas = 0; gap_run = 0; rem = 0; cnt_exp = '0;
        forever begin
            @(negedge clock);
            if (resetn !== 1'b1) begin
                in_pkt = 0; par_phase = 0; done_exp = 0; gap_meas = 0;
                continue;
            end
            if (done_exp || done === 1'b1) begin
                check("done_pulse", {31'd0, done}, {31'd0, done_exp});
                if (done_exp) check("pkt_cnt", {30'd0, pkt_cnt}, {30'd0, cnt_exp});
                done_exp = 0;
            end
            if (gap_meas) begin
                if (tx_ready === 1'b1) begin
                    check("gap_len", gap_run, IDLE_GAP);
                    gap_meas = 0;
                end else begin
                    gap_run++;
                end
            end
            if (in_pkt || pkt_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_byte", {31'd0, pkt_valid}, 32'd0);
                    in_pkt = 0;
                end else begin
                    e = sbq[0];
                    check(busy ? "held_byte" : "data_out", {24'd0, data_out}, {24'd0, e.data});
                    check("pkt_valid", {31'd0, pkt_valid}, {31'd0, e.valid});
                    if (!busy) begin
                        void'(sbq.pop_front());
                        $display("byte %02h valid=%0b last=%0b", data_out, pkt_valid, e.last);
                        if (par_phase) begin
                            check("exp_parity", {24'd0, exp_parity}, {24'd0, e.par});
                            par_phase = 0; in_pkt = 0;
                            done_exp = 1; cnt_exp = e.cnt;
                            gap_meas = 1; gap_run = 0;
                        end else if (!in_pkt) begin
                            in_pkt = 1;
                            rem = int'(data_out[7:2]);
                            if (rem == 0) par_phase = 1;
                        end else begin
                            rem--;
                            if (rem == 0) par_phase = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        resetn = 1'b0; start = 1'b0; dest_addr = '0; payload_len = '0;
        seed = '0; corrupt_parity = 1'b0; busy = 1'b0;
        #12;
        check("rst_tx_ready",   {31'd0, tx_ready},   32'd1);
        check("rst_pkt_valid",  {31'd0, pkt_valid},  32'd0);
        check("rst_data_out",   {24'd0, data_out},   32'd0);
        check("rst_done",       {31'd0, done},       32'd0);
        check("rst_cfg_err",    {31'd0, cfg_err},    32'd0);
        check("rst_exp_parity", {24'd0, exp_parity}, 32'd0);
        check("rst_pkt_cnt",    {30'd0, pkt_cnt},    32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;

        // Basic packet: addr 2, len 3, seed 01
        send(2'd2, 6'd3, 8'h01, 1'b0, 64'h0E_01_02_04_09, 5);
        wait_drain();

        // Corrupted parity, with busy held over the first two header cycles
        send(2'd2, 6'd3, 8'h01, 1'b1, 64'h0E_01_02_04_09, 5);
        busy = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        busy = 1'b0;
        wait_drain();

        // busy for 3 cycles on the second payload byte
        send(2'd2, 6'd3, 8'h01, 1'b0, 64'h0E_01_02_04_09, 5);
        @(posedge clock); #1;
        @(posedge clock); #1;
        busy = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        busy = 1'b0;
        wait_drain();

        // Rejected starts: bad address, then zero length
        dest_addr = 2'd3; payload_len = 6'd3; seed = 8'h01; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("cfg_err_addr",   {31'd0, cfg_err},   32'd1);
        check("rej_tx_ready",   {31'd0, tx_ready},  32'd1);
        check("rej_pkt_valid",  {31'd0, pkt_valid}, 32'd0);
        @(posedge clock); #1;
        check("cfg_err_clear",  {31'd0, cfg_err},   32'd0);
        dest_addr = 2'd1; payload_len = 6'd0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("cfg_err_len",    {31'd0, cfg_err},   32'd1);
        check("rej_tx_ready2",  {31'd0, tx_ready},  32'd1);
        @(posedge clock); #1;
        check("cfg_err_clear2", {31'd0, cfg_err},   32'd0);
        check("rej_pkt_cnt",    {30'd0, pkt_cnt},   {30'd0, exp_cnt});
        check("rej_pkt_valid2", {31'd0, pkt_valid}, 32'd0);

        // Reset during payload abandons the packet
        send(2'd2, 6'd3, 8'h01, 1'b0, 64'h0E_01_02_04_09, 5);
        repeat (2) begin @(posedge clock); #1; end
        resetn = 1'b0;
        sbq.delete();
        exp_cnt = '0;
        #1;
        check("mid_rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        check("mid_rst_tx_ready",  {31'd0, tx_ready},  32'd1);
        check("mid_rst_data_out",  {24'd0, data_out},  32'd0);
        check("mid_rst_pkt_cnt",   {30'd0, pkt_cnt},   32'd0);
        @(negedge clock);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        send(2'd2, 6'd3, 8'h01, 1'b0, 64'h0E_01_02_04_09, 5);
        wait_drain();

        // Back-to-back with start held high; config changes mid-packet must not leak
        wait_ready();
        dest_addr = 2'd0; payload_len = 6'd1; seed = 8'h80; corrupt_parity = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        push_pkt(64'h04_80_84, 3, 1'b0);
        dest_addr = 2'd1; payload_len = 6'd2; seed = 8'h00;
        wait_ready();
        @(posedge clock); #1;
        push_pkt(64'h09_01_02_0A, 4, 1'b0);
        dest_addr = 2'd0; payload_len = 6'd4; seed = 8'h38;
        wait_ready();
        @(posedge clock); #1;
        push_pkt(64'h10_38_71_E2_C4_7F, 6, 1'b0);
        dest_addr = 2'd2; payload_len = 6'd3; seed = 8'h01;
        wait_ready();
        @(posedge clock); #1;
        start = 1'b0;
        push_pkt(64'h0E_01_02_04_09, 5, 1'b0);
        wait_drain();
        repeat (3) begin @(posedge clock); #1; end
        check("final_pkt_cnt", {30'd0, pkt_cnt}, {30'd0, exp_cnt});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
